pot_bank_ctrl: RTL and testbench

POT_BANK_CTRL -- requirements
Module: pot_bank_ctrl

---
 rtl/pot_bank_ctrl_if.sv | 31 +++
 rtl/pot_bank_ctrl.sv | 156 +++++++++++++++
 tb/tb_pot_bank_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pot_bank_ctrl_if.sv
// rtl/pot_bank_ctrl_if.sv - host/pot-channel signal bundle for pot_bank_ctrl
interface pot_bank_ctrl_if;
    // Pot channel side
    logic [31:0] Position;
    logic [7:0]  Set;
    logic [3:0]  Latch;
    // Host single-channel write
    logic        Wr_Req;
    logic [1:0]  Wr_Ch;
    logic [7:0]  Wr_Data;
    logic        Wr_Ack;
    // Preset recall/store
    logic        Recall_Req;
    logic        Store_Req;
    logic [1:0]  Slot;
    logic        Recall_Ack;
    logic        Store_Ack;
    logic        Busy;

    // Host / environment side: drives requests and pot positions
    modport master (
        output Position, Wr_Req, Wr_Ch, Wr_Data, Recall_Req, Store_Req, Slot,
        input  Set, Latch, Wr_Ack, Recall_Ack, Store_Ack, Busy
    );

    // Controller side
    modport slave (
        input  Position, Wr_Req, Wr_Ch, Wr_Data, Recall_Req, Store_Req, Slot,
        output Set, Latch, Wr_Ack, Recall_Ack, Store_Ack, Busy
    );
endinterface

// File: rtl/pot_bank_ctrl.sv
// rtl/pot_bank_ctrl.sv - four-channel pot loader with preset bank (store enabled by POT_BANK_PRESET_STORE_EN)
module pot_bank_ctrl #(
    parameter logic [7:0] Default = 8'h00
) (
    input  logic           Clk,
    input  logic           Reset,
    pot_bank_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_RECALL = 2'd2;
`ifdef POT_BANK_PRESET_STORE_EN
    localparam logic [1:0] ST_STORE  = 2'd3;
`endif

    logic [1:0] state_q, state_d;
    logic [1:0] slot_q,  slot_d;
    logic [1:0] ch_q,    ch_d;
    logic [7:0] data_q,  data_d;
    logic [1:0] idx_q,   idx_d;
    logic [7:0] set_q,   set_d;

    // Preset bank: [slot][channel] bytes, channel 0 in the low byte of each slot
    logic [3:0][3:0][7:0] mem_q;
`ifdef POT_BANK_PRESET_STORE_EN
    logic [3:0][3:0][7:0] mem_d;
`else
    logic unused_store;
    assign mem_q        = {16{Default}};
    assign unused_store = ^{bus.Store_Req, bus.Position};
`endif

    logic [3:0] latch;
    logic       wr_ack;
    logic       recall_ack;
    logic       store_ack;

    // Request arbitration in IDLE and sequencing of the multi-cycle operations
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        ch_d    = ch_q;
        data_d  = data_q;
        idx_d   = idx_q;
`ifdef POT_BANK_PRESET_STORE_EN
        mem_d   = mem_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef POT_BANK_PRESET_STORE_EN
                if (bus.Store_Req) begin
                    // Positions are snapshotted on the accepting edge so later
                    // input motion cannot disturb the stored preset.
                    state_d          = ST_STORE;
                    slot_d           = bus.Slot;
                    mem_d[bus.Slot]  = bus.Position;
                end else
`endif
                if (bus.Recall_Req) begin
                    state_d = ST_RECALL;
                    slot_d  = bus.Slot;
                    idx_d   = 2'd0;
                end else if (bus.Wr_Req) begin
                    state_d = ST_WRITE;
                    ch_d    = bus.Wr_Ch;
                    data_d  = bus.Wr_Data;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_RECALL: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef POT_BANK_PRESET_STORE_EN
            ST_STORE: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes and acks follow the current state; Set holds its last value when idle
    always_comb begin
        latch      = 4'b0000;
        wr_ack     = 1'b0;
        recall_ack = 1'b0;
        store_ack  = 1'b0;
        set_d      = set_q;
        case (state_q)
            ST_WRITE: begin
                latch  = 4'b0001 << ch_q;
                set_d  = data_q;
                wr_ack = 1'b1;
            end
            ST_RECALL: begin
                latch      = 4'b0001 << idx_q;
                set_d      = mem_q[slot_q][idx_q];
                recall_ack = (idx_q == 2'd3);
            end
`ifdef POT_BANK_PRESET_STORE_EN
            ST_STORE: begin
                store_ack = 1'b1;
            end
`endif
            default: begin
                latch = 4'b0000;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            slot_q  <= 2'd0;
            ch_q    <= 2'd0;
            data_q  <= 8'h00;
            idx_q   <= 2'd0;
            set_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            set_q   <= set_d;
        end
    end

`ifdef POT_BANK_PRESET_STORE_EN
    // Preset bank storage, cleared to Default on reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_q <= {16{Default}};
        end else begin
            mem_q <= mem_d;
        end
    end
`endif

    assign bus.Set        = set_d;
    assign bus.Latch      = latch;
    assign bus.Wr_Ack     = wr_ack;
    assign bus.Recall_Ack = recall_ack;
    assign bus.Store_Ack  = store_ack;
    assign bus.Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pot_bank_ctrl.sv
// tb/tb_pot_bank_ctrl.sv - self-checking bench for pot_bank_ctrl
module tb_pot_bank_ctrl;

    localparam logic [7:0] DEF = 8'h5C;
`ifdef POT_BANK_PRESET_STORE_EN
    localparam bit STORE_EN = 1'b1;
`else
    localparam bit STORE_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pot_bank_ctrl_if bus ();

    pot_bank_ctrl #(.Default(DEF)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] set;
        logic [3:0] latch;
        logic       wa;
        logic       ra;
        logic       sa;
        logic       busy;
    } exp_t;

    exp_t       q[$];
    exp_t       cur = '0;
    logic [7:0] mmem [4][4];

    // Transaction-level model: when the previous cycle was idle, expand the winning request into per-cycle expectations
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q.delete();
            cur = '0;
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < 4; c++)
                    mmem[s][c] = DEF;
        end else begin
            if (q.size() == 0 && !cur.busy) begin
                if (STORE_EN && bus.Store_Req) begin
                    for (int c = 0; c < 4; c++)
                        mmem[bus.Slot][c] = bus.Position[8*c +: 8];
                    q.push_back('{set: cur.set, latch: 4'b0, wa: 1'b0, ra: 1'b0, sa: 1'b1, busy: 1'b1});
                end else if (bus.Recall_Req) begin
                    for (int c = 0; c < 4; c++)
                        q.push_back('{set: mmem[bus.Slot][c], latch: 4'(1 << c), wa: 1'b0,
                                      ra: (c == 3), sa: 1'b0, busy: 1'b1});
                end else if (bus.Wr_Req) begin
                    q.push_back('{set: bus.Wr_Data, latch: 4'(1 << bus.Wr_Ch), wa: 1'b1,
                                  ra: 1'b0, sa: 1'b0, busy: 1'b1});
                end
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = '{set: cur.set, latch: 4'b0, wa: 1'b0, ra: 1'b0, sa: 1'b0, busy: 1'b0};
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge Clk) begin
        checks++;
        if (bus.Set !== cur.set || bus.Latch !== cur.latch || bus.Wr_Ack !== cur.wa ||
            bus.Recall_Ack !== cur.ra || bus.Store_Ack !== cur.sa || bus.Busy !== cur.busy) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t Set=%h/%h Latch=%b/%b WrAck=%b/%b RecAck=%b/%b StAck=%b/%b Busy=%b/%b (got/expected)",
                     $time, bus.Set, cur.set, bus.Latch, cur.latch, bus.Wr_Ack, cur.wa,
                     bus.Recall_Ack, cur.ra, bus.Store_Ack, cur.sa, bus.Busy, cur.busy);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    logic [7:0] rec_exp [4];

    initial begin
        bus.Position   = 32'h0;
        bus.Wr_Req     = 1'b0;
        bus.Wr_Ch      = 2'd0;
        bus.Wr_Data    = 8'h00;
        bus.Recall_Req = 1'b0;
        bus.Store_Req  = 1'b0;
        bus.Slot       = 2'd0;

        // Reset state
        tick(2);
        chk("rst_set", {24'h0, bus.Set}, 32'h00);
        chk("rst_latch", {28'h0, bus.Latch}, 32'h0);
        chk("rst_busy_acks", {28'h0, bus.Busy, bus.Wr_Ack, bus.Recall_Ack, bus.Store_Ack}, 32'h0);
        Reset = 1'b0;
        tick();

        // Single write, data changed while busy
        bus.Wr_Req = 1'b1; bus.Wr_Ch = 2'd2; bus.Wr_Data = 8'hA5;
        tick();
        bus.Wr_Req = 1'b0; bus.Wr_Data = 8'hFF;
        chk("wr_set", {24'h0, bus.Set}, 32'hA5);
        chk("wr_latch", {28'h0, bus.Latch}, 32'h4);
        chk("wr_ack_busy", {30'h0, bus.Wr_Ack, bus.Busy}, 32'h3);
        tick();
        chk("wr_idle", {27'h0, bus.Busy, bus.Latch}, 32'h0);
        chk("wr_set_hold", {24'h0, bus.Set}, 32'hA5);

        // Store slot 1 then recall it
        bus.Position = 32'h44332211; bus.Store_Req = 1'b1; bus.Slot = 2'd1;
        tick();
        bus.Store_Req = 1'b0; bus.Slot = 2'd3; bus.Position = 32'hFFFFFFFF;
`ifdef POT_BANK_PRESET_STORE_EN
        chk("store_ack", {27'h0, bus.Store_Ack, bus.Latch}, 32'h10);
        rec_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
`else
        chk("store_ignored", {30'h0, bus.Store_Ack, bus.Busy}, 32'h0);
        rec_exp = '{DEF, DEF, DEF, DEF};
`endif
        tick();
        bus.Recall_Req = 1'b1; bus.Slot = 2'd1;
        tick();
        bus.Recall_Req = 1'b0; bus.Slot = 2'd2;
        for (int i = 0; i < 4; i++) begin
            chk("rec_set", {24'h0, bus.Set}, {24'h0, rec_exp[i]});
            chk("rec_latch_ack", {27'h0, bus.Recall_Ack, bus.Latch}, {27'h0, (i == 3), 4'(1 << i)});
            tick();
        end
        chk("rec_done", {31'h0, bus.Busy}, 32'h0);

        // Recall and write on the same edge: recall wins, write pending
        bus.Recall_Req = 1'b1; bus.Slot = 2'd0;
        bus.Wr_Req = 1'b1; bus.Wr_Ch = 2'd1; bus.Wr_Data = 8'h3C;
        tick();
        bus.Recall_Req = 1'b0;
        chk("pri_first", {28'h0, bus.Latch}, 32'h1);
        tick(3);
        chk("pri_rec_ack", {27'h0, bus.Recall_Ack, bus.Latch}, 32'h18);
        tick();
        chk("pri_gap", {27'h0, bus.Busy, bus.Latch}, 32'h0);
        tick();
        chk("pri_wr", {19'h0, bus.Wr_Ack, bus.Set, bus.Latch}, {19'h0, 1'b1, 8'h3C, 4'b0010});
        bus.Wr_Req = 1'b0;
        tick();

        // Reset during second recall cycle
        bus.Recall_Req = 1'b1; bus.Slot = 2'd1;
        tick();
        bus.Recall_Req = 1'b0;
        tick();
        chk("abort_pre", {28'h0, bus.Latch}, 32'h2);
        #1 Reset = 1'b1;
        #1;
        chk("abort_now", {19'h0, bus.Busy, bus.Set, bus.Latch}, 32'h0);
        tick(2);
        Reset = 1'b0;
        tick(3);
        bus.Recall_Req = 1'b1; bus.Slot = 2'd1;
        tick();
        bus.Recall_Req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_set", {24'h0, bus.Set}, {24'h0, DEF});
            tick();
        end

        // Held write request: one strobe every other cycle
        bus.Wr_Req = 1'b1; bus.Wr_Ch = 2'd0; bus.Wr_Data = 8'h70;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus.Wr_Data = 8'h70 + 8'(k);
            chk("held_wr", {29'h0, bus.Latch[0], bus.Busy, bus.Wr_Ack},
                (k % 2 == 1) ? 32'h7 : 32'h0);
        end
        bus.Wr_Req = 1'b0;
        tick(2);

        // All three requests at once with staggered release
        bus.Position = 32'hDEADBEEF;
        bus.Store_Req = 1'b1; bus.Recall_Req = 1'b1; bus.Wr_Req = 1'b1;
        bus.Slot = 2'd3; bus.Wr_Ch = 2'd3; bus.Wr_Data = 8'hE1;
        tick();
        bus.Store_Req = 1'b0; bus.Position = 32'h0;
        tick(2);
        bus.Recall_Req = 1'b0;
        tick(8);
        bus.Wr_Req = 1'b0;
        tick(3);
        bus.Recall_Req = 1'b1; bus.Slot = 2'd3;
        tick();
        bus.Recall_Req = 1'b0;
        tick(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
